phy_urx2: RTL and testbench
===========================

Name: phy_urx2

Overview:
- UART receiver for the chip debug link; the receive-side counterpart of phy_utx2.
- Deserialises 8N1 bytes from the serial line, timed by the 1 us tick pluse_us.
- Pairs consecutive bytes into a 16-bit word, high byte first, and presents it with a one-cycle valid strobe.
- Intended for bench loopback and for board-to-board links that carry tx_data words.

Parameters:
- BIT_US, 8, microseconds per bit (125 kbaud default); legal range 4..255.
- GAP_US, 100, maximum microseconds from the high byte's stop-bit sample to the low byte's start edge; legal range 1..65535.

Ports:
- clk_sys  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pluse_us  input  1  one-clk_sys-cycle pulse every 1 us.
- uart_rx  input  1  serial line, idle high, asynchronous to clk_sys.
- rx_data  output  16  last complete word; bits [15:8] = first byte received.
- rx_vld  output  1  one-cycle pulse when rx_data is updated.
- rx_err  output  1  one-cycle pulse on a receive error.
- rx_err_code  output  2  cause of the last error: 01 frame, 10 gap timeout, 11 parity; holds until the next error.

Behaviour:
- Reset and clocking:
  - One clock (clk_sys). Reset is asynchronous and active-low on rst_n.
  - Reset values: rx_data=0, rx_vld=0, rx_err=0, rx_err_code=0, state=IDLE, byte phase=HI, synchroniser flops=1.
- Input synchroniser: uart_rx passes through 2 flops, then 1 more flop for edge detect. Every decision below uses the synchronised value.
- Bit timing:
  - An 8-bit us counter counts pluse_us only and clears on each state entry.
  - "Half bit" = BIT_US/2 pulses, truncated. "Full bit" = BIT_US pulses.
- State machine:
  - IDLE: a falling edge on the line moves to START.
  - START: after a half bit, sample the line.
    - Low: go to DATA with bit index 0.
    - High: glitch; return to IDLE with no error.
  - DATA: after each full bit, shift the sample into the byte LSB-first. After bit index 7, go to STOP (or to PARITY when the feature is built in).
  - STOP: after a full bit, sample the line.
    - High: byte accepted.
    - Low: frame error; go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line is sampled high for one full bit, then go to IDLE. This discards any held high byte and sets phase=HI.
- Byte pairing:
  - Byte accepted with phase=HI: store it as the high byte, set phase=LO, start the gap counter.
  - Byte accepted with phase=LO: on the next clk_sys cycle, update rx_data to {hi, lo} and pulse rx_vld for exactly 1 cycle; set phase=HI.
  - Latency: rx_vld rises 1 clk_sys cycle after the stop-bit sample of the low byte.
- Gap timeout:
  - A 16-bit gap counter counts pluse_us while phase=LO and state=IDLE.
  - When the count reaches GAP_US: pulse rx_err, set rx_err_code=10, discard the high byte, set phase=HI.
  - If a start edge and the timeout fall in the same cycle, the timeout wins; the edge is then treated as the start of a new high byte.
- Errors:
  - rx_err pulses for 1 cycle and is never asserted in the same cycle as rx_vld.
  - rx_data is unchanged on any error.
- Reset mid-byte: everything returns to reset values immediately. The next falling edge starts a fresh high byte.
- A line held low at or after reset release is not a start edge. IDLE requires a falling edge.
- pluse_us asserted on consecutive cycles is counted each cycle; no debounce.

Optional Feature:
- Macro: PHY_URX2_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one more bit after a full bit. Framing becomes 8E1.
  - Even parity over the 8 data bits plus the parity bit must hold.
  - On mismatch: rx_err pulses with rx_err_code=11, the byte is discarded, phase=HI, and the state goes to STOP. STOP still checks framing; a low stop bit there does not raise a second error pulse.
- Undefined: no PARITY state. Framing is 8N1. Code 11 is never produced.

Test Plan:
- BIT_US=8. Send bytes 0xA5 then 0x5A back-to-back, 8N1 -> exactly one rx_vld pulse, rx_data=0xA55A, 1 cycle after the second stop-bit sample; rx_err stays 0.
- Send 0x12, idle 150 us (GAP_US=100), then send 0x34 -> at 100 us: rx_err pulse, rx_err_code=10, rx_data still 0. 0x34 becomes the high byte; following it with 0x56 yields rx_data=0x3456.
- Send 0xFF with the stop bit forced low, release the line high, then send 0x01, 0x02 -> rx_err with code 01; then rx_vld with rx_data=0x0102.
- Drive a 2 us low glitch on an idle line -> START samples high and returns to IDLE; no rx_vld, no rx_err. A following word 0xBEEF is received correctly.
- Assert rst_n low during bit 3 of a high byte, release, then send 0xC0, 0xDE -> all outputs 0 during reset; then rx_data=0xC0DE.
- With PHY_URX2_PARITY_EN: send 0x03 with parity bit 1, then 0x03, 0x81 with correct parity bits 0 and 0 -> rx_err code 11 for the first byte, then rx_data=0x0381.

Source files
------------

// File: rtl/phy_urx2.sv
// phy_urx2 - debug-link UART receiver.
// Samples the line on the 1 us tick, assembles 8N1 bytes (8E1 when
// PHY_URX2_PARITY_EN is defined) and pairs consecutive bytes into a
// 16-bit word, high byte first. A timeout on the gap between the two
// bytes, a bad stop bit or a parity mismatch raises an error pulse.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge
// START     | half a bit in, confirm the start bit is still low
// DATA      | sample 8 data bits, LSB first, one per full bit
// PARITY    | sample the even-parity bit (parity build only)
// STOP      | sample the stop bit, accept the byte if it is high
// WAIT_IDLE | after a frame error, wait for one full bit of high line
module phy_urx2 #(
  parameter int BIT_US = 8,
  parameter int GAP_US = 100
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic        uart_rx,
  output logic [15:0] rx_data,
  output logic        rx_vld,
  output logic        rx_err,
  output logic [1:0]  rx_err_code
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef PHY_URX2_PARITY_EN
    PARITY    = 3'd5,
`endif
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [7:0]  HALF_M1 = 8'(BIT_US / 2 - 1);
  localparam logic [7:0]  FULL_M1 = 8'(BIT_US - 1);
  localparam logic [15:0] GAP_M1  = 16'(GAP_US - 1);

  state_t      state, state_nxt;
  logic        rx_s1, rx_s2, rx_s3;
  logic [1:0]  settle_cnt;
  logic [7:0]  us_cnt;
  logic [15:0] gap_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  hi_byte;
  logic        phase_lo;
  logic        lo_pend;

  logic        fall, tick_half, tick_full, gap_hit;
  logic        us_clr, shift_en, idx_clr, byte_ok, frame_err, wait_done;
`ifdef PHY_URX2_PARITY_EN
  logic        par_err, par_bad;
`endif

  // Until the edge-detect flop holds a real line sample (three clocks after
  // reset) a low line must not look like a start edge.
  assign fall      = (settle_cnt == 2'd3) && rx_s3 && !rx_s2;
  assign tick_half = pluse_us && (us_cnt == HALF_M1);
  assign tick_full = pluse_us && (us_cnt == FULL_M1);
  assign gap_hit   = (state == IDLE) && phase_lo && pluse_us && (gap_cnt == GAP_M1);

  // Two-flop synchroniser plus edge-detect flop, and the post-reset settle count.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      settle_cnt <= 2'd0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
    end
  end

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    us_clr    = 1'b0;
    shift_en  = 1'b0;
    idx_clr   = 1'b0;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    wait_done = 1'b0;
`ifdef PHY_URX2_PARITY_EN
    par_err   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          us_clr    = 1'b1;
        end
      end
      START: begin
        if (tick_half) begin
          us_clr = 1'b1;
          if (!rx_s2) begin
            state_nxt = DATA;
            idx_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_full) begin
          us_clr   = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef PHY_URX2_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef PHY_URX2_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          us_clr    = 1'b1;
          state_nxt = STOP;
          par_err   = ^{shreg, rx_s2};
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          us_clr = 1'b1;
          if (rx_s2) begin
            state_nxt = IDLE;
`ifdef PHY_URX2_PARITY_EN
            byte_ok   = !par_bad;
`else
            byte_ok   = 1'b1;
`endif
          end else begin
            state_nxt = WAIT_IDLE;
            // A byte already rejected for parity gets only one error pulse.
`ifdef PHY_URX2_PARITY_EN
            frame_err = !par_bad;
`else
            frame_err = 1'b1;
`endif
          end
        end
      end
      WAIT_IDLE: begin
        if (!rx_s2) begin
          us_clr = 1'b1;
        end else if (tick_full) begin
          us_clr    = 1'b1;
          wait_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-period counter, bit index and receive shift register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt  <= 8'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      if (us_clr)        us_cnt <= 8'd0;
      else if (pluse_us) us_cnt <= us_cnt + 8'd1;
      if (idx_clr)       bit_idx <= 3'd0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en)      shreg <= {rx_s2, shreg[7:1]};
    end
  end

`ifdef PHY_URX2_PARITY_EN
  // Remembers a parity failure until the stop bit of the same byte is done.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                          par_bad <= 1'b0;
    else if (par_err)                    par_bad <= 1'b1;
    else if (state == STOP && tick_full) par_bad <= 1'b0;
  end
`endif

  // Byte pairing, gap timeout and the output registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      phase_lo    <= 1'b0;
      hi_byte     <= 8'd0;
      lo_pend     <= 1'b0;
      gap_cnt     <= 16'd0;
      rx_data     <= 16'd0;
      rx_vld      <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= 2'd0;
    end else begin
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
      lo_pend <= 1'b0;

      if (byte_ok && !phase_lo)
        gap_cnt <= 16'd0;
      else if (state == IDLE && phase_lo && pluse_us)
        gap_cnt <= gap_cnt + 16'd1;

      if (byte_ok) begin
        if (!phase_lo) begin
          hi_byte  <= shreg;
          phase_lo <= 1'b1;
        end else begin
          lo_pend  <= 1'b1;
          phase_lo <= 1'b0;
        end
      end

      // shreg still holds the low byte here: DATA cannot be re-entered yet.
      if (lo_pend) begin
        rx_data <= {hi_byte, shreg};
        rx_vld  <= 1'b1;
      end

      if (gap_hit) begin
        rx_err      <= 1'b1;
        rx_err_code <= 2'b10;
        phase_lo    <= 1'b0;
      end
      if (frame_err) begin
        rx_err      <= 1'b1;
        rx_err_code <= 2'b01;
      end
`ifdef PHY_URX2_PARITY_EN
      if (par_err) begin
        rx_err      <= 1'b1;
        rx_err_code <= 2'b11;
        phase_lo    <= 1'b0;
      end
`endif
      if (wait_done) phase_lo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phy_urx2.sv
// tb_phy_urx2 - directed and randomized stimulus for phy_urx2 with a
// byte-level reference model (framing, pairing and gap rules in microseconds).
module tb_phy_urx2;

  localparam int BIT_US = 8;
  localparam int GAP_US = 100;
  localparam int HALF   = BIT_US / 2;
  localparam int CPU    = 4;           // clk_sys cycles per microsecond tick

  logic        clk_sys  = 1'b0;
  logic        rst_n    = 1'b0;
  logic        pluse_us = 1'b0;
  logic        uart_rx  = 1'b1;
  logic [15:0] rx_data;
  logic        rx_vld;
  logic        rx_err;
  logic [1:0]  rx_err_code;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int div    = 0;

  phy_urx2 #(.BIT_US(BIT_US), .GAP_US(GAP_US)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .pluse_us    (pluse_us),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_vld      (rx_vld),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code)
  );

  // Clock, negedge cycle count and the 1 us tick, all from one process.
  initial begin
    forever begin
      #5 clk_sys = 1'b1;
      #5 clk_sys = 1'b0;
      cyc++;
      div      = (div + 1) % CPU;
      pluse_us = (div == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observed events.
  int          got_vld_data[$], got_vld_cyc[$], got_err_code[$], got_err_cyc[$];
  logic        prev_vld = 1'b0;
  logic [15:0] last_word = 16'd0;

  initial begin
    forever begin
      @(negedge clk_sys);
      if (rx_vld) begin
        chk("vld_width", {31'd0, prev_vld}, 32'd0);
        chk("vld_err_excl", {31'd0, rx_err}, 32'd0);
        got_vld_data.push_back(int'(rx_data));
        got_vld_cyc.push_back(cyc);
        last_word = rx_data;
      end
      if (rx_err) begin
        chk("err_keeps_data", {16'd0, rx_data}, {16'd0, last_word});
        got_err_code.push_back(int'(rx_err_code));
        got_err_cyc.push_back(cyc);
      end
      prev_vld = rx_vld;
    end
  end

  // Reference model: expected events with the cycle they should be seen.
  int         exp_vld_data[$], exp_vld_cyc[$], exp_err_code[$], exp_err_cyc[$];
  bit         have_hi = 1'b0;
  logic [7:0] hi_b    = 8'd0;
  int         hi_stop_cyc = 0;

  task automatic tick(input int n);
    repeat (n) begin
      do @(negedge clk_sys); while (!pluse_us);
    end
  endtask

  // Microseconds from the held high byte's stop sample decide the timeout.
  task automatic check_gap();
    if (have_hi && ((cyc - hi_stop_cyc) / CPU - HALF) >= GAP_US) begin
      exp_err_code.push_back(2);
      exp_err_cyc.push_back(hi_stop_cyc + HALF * CPU + 1 + GAP_US * CPU);
      have_hi = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    tick(n);
    check_gap();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    int stop_cyc;
    bit bad_par;
    bad_par = 1'b0;
    check_gap();
    uart_rx = 1'b0;
    tick(BIT_US);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(BIT_US);
    end
`ifdef PHY_URX2_PARITY_EN
    uart_rx = (^b) ^ !par_ok;
    if (!par_ok) begin
      exp_err_code.push_back(3);
      exp_err_cyc.push_back(cyc + HALF * CPU + 1);
      have_hi = 1'b0;
      bad_par = 1'b1;
    end
    tick(BIT_US);
`else
    if (!par_ok) bad_par = 1'b0;
`endif
    stop_cyc = cyc;
    uart_rx  = stop_ok;
    tick(BIT_US);
    uart_rx  = 1'b1;
    if (!stop_ok) begin
      if (!bad_par) begin
        exp_err_code.push_back(1);
        exp_err_cyc.push_back(stop_cyc + HALF * CPU + 1);
      end
      have_hi = 1'b0;
    end else if (!bad_par) begin
      if (have_hi) begin
        exp_vld_data.push_back(int'({hi_b, b}));
        exp_vld_cyc.push_back(stop_cyc + HALF * CPU + 2);
        have_hi = 1'b0;
      end else begin
        have_hi     = 1'b1;
        hi_b        = b;
        hi_stop_cyc = stop_cyc;
      end
    end
  endtask

  function automatic logic [31:0] near(input int got, input int exp);
    int d;
    d = got - exp;
    return (d >= -1 && d <= 1) ? 32'd0 : 32'(d);
  endfunction

  task automatic verify(input string tag);
    int n;
    chk({tag, "_vld_count"}, 32'(got_vld_data.size()), 32'(exp_vld_data.size()));
    chk({tag, "_err_count"}, 32'(got_err_code.size()), 32'(exp_err_code.size()));
    n = (got_vld_data.size() < exp_vld_data.size()) ? got_vld_data.size() : exp_vld_data.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 32'(got_vld_data[i]), 32'(exp_vld_data[i]));
      chk({tag, "_vld_time"}, near(got_vld_cyc[i], exp_vld_cyc[i]), 32'd0);
    end
    n = (got_err_code.size() < exp_err_code.size()) ? got_err_code.size() : exp_err_code.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_err_code"}, 32'(got_err_code[i]), 32'(exp_err_code[i]));
      chk({tag, "_err_time"}, near(got_err_cyc[i], exp_err_cyc[i]), 32'd0);
    end
    got_vld_data.delete(); got_vld_cyc.delete(); got_err_code.delete(); got_err_cyc.delete();
    exp_vld_data.delete(); exp_vld_cyc.delete(); exp_err_code.delete(); exp_err_cyc.delete();
  endtask

  initial begin
    logic [15:0] w;
    int          g;

    // Reset values.
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk_sys);
    chk("rst_data", {16'd0, rx_data}, 32'd0);
    chk("rst_vld", {31'd0, rx_vld}, 32'd0);
    chk("rst_err", {31'd0, rx_err}, 32'd0);
    chk("rst_code", {30'd0, rx_err_code}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Gap timeout: 0x12, 150 us idle, then 0x34 0x56.
    send_byte(8'h12, 1'b1, 1'b1);
    idle(150);
    send_byte(8'h34, 1'b1, 1'b1);
    send_byte(8'h56, 1'b1, 1'b1);
    idle(12);
    verify("gap");
    chk("gap_code_hold", {30'd0, rx_err_code}, 32'd2);

    // Back-to-back word.
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h5A, 1'b1, 1'b1);
    idle(12);
    verify("b2b");

    // Frame error, then a good word.
    send_byte(8'hFF, 1'b0, 1'b1);
    idle(16);
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h02, 1'b1, 1'b1);
    idle(12);
    verify("frame");

    // Short low glitch on an idle line, then 0xBEEF.
    uart_rx = 1'b0;
    tick(2);
    idle(20);
    verify("glitch");
    send_byte(8'hBE, 1'b1, 1'b1);
    send_byte(8'hEF, 1'b1, 1'b1);
    idle(12);
    verify("beef");

    // Reset during bit 3 of a high byte.
    uart_rx = 1'b0;
    tick(BIT_US);
    uart_rx = 1'b1; tick(BIT_US);
    uart_rx = 1'b0; tick(BIT_US);
    uart_rx = 1'b1; tick(BIT_US);
    uart_rx = 1'b0; tick(3);
    rst_n = 1'b0;
    @(negedge clk_sys);
    chk("mid_rst_data", {16'd0, rx_data}, 32'd0);
    chk("mid_rst_vld", {31'd0, rx_vld}, 32'd0);
    chk("mid_rst_err", {31'd0, rx_err}, 32'd0);
    chk("mid_rst_code", {30'd0, rx_err_code}, 32'd0);
    uart_rx   = 1'b1;
    have_hi   = 1'b0;
    last_word = 16'd0;
    tick(2);
    rst_n = 1'b1;
    idle(20);
    send_byte(8'hC0, 1'b1, 1'b1);
    send_byte(8'hDE, 1'b1, 1'b1);
    idle(12);
    verify("reset");

`ifdef PHY_URX2_PARITY_EN
    // Parity error on the first byte, then a correctly paired word.
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h03, 1'b1, 1'b1);
    send_byte(8'h81, 1'b1, 1'b1);
    idle(12);
    verify("parity");
`endif

    // Randomized words with gaps clear of the timeout threshold.
    for (int k = 0; k < 6; k++) begin
      w = 16'($urandom);
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 160)) : int'($urandom_range(0, 60));
      send_byte(w[15:8], 1'b1, 1'b1);
      idle(g);
      send_byte(w[7:0], 1'b1, 1'b1);
      idle(int'($urandom_range(0, 40)));
    end
    idle(150);
    verify("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
